// File: rtl/rom_stream_reader.sv
// Reads a contiguous address range out of a registered-read template ROM and streams the words
// on a valid/ready interface, with a small FIFO absorbing consumer back-pressure.
module rom_stream_reader #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam int unsigned PipeDepth   = 1 + RD_LATENCY;
    localparam int unsigned PtrWidth    = $clog2(FIFO_DEPTH);
    localparam int unsigned CntWidth    = PtrWidth + 1;
    localparam int unsigned CreditWidth = $clog2(FIFO_DEPTH + PipeDepth + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   rom_addr_q;
    logic [ADDR_WIDTH:0]     remaining_q;
    logic [PipeDepth-1:0]    pipe_vld_q;
    logic [PipeDepth-1:0]    pipe_last_q;
    logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_last_q;
    logic [PtrWidth-1:0]     wr_ptr_q;
    logic [PtrWidth-1:0]     rd_ptr_q;
    logic [CntWidth-1:0]     count_q;

    logic                    start_ok;
    logic                    issue_first;
    logic                    issue_next;
    logic                    issue;
    logic                    issue_last;
    logic                    push;
    logic                    pop;
    logic [CreditWidth-1:0]  credit_used;

    // Words already in the FIFO plus words still travelling through the ROM read pipe.
    always_comb begin
        credit_used = CreditWidth'(count_q);
        for (int i = 0; i < int'(PipeDepth); i++) begin
            credit_used = credit_used + CreditWidth'(pipe_vld_q[i]);
        end
    end

    always_comb begin
        start_ok    = (state_q == StIdle) && start;
        issue_first = start_ok && (length != '0);
        issue_next  = (state_q == StRun) && (remaining_q != '0) &&
                      (credit_used < CreditWidth'(FIFO_DEPTH));
        issue       = issue_first || issue_next;
        issue_last  = issue_first ? (length == (ADDR_WIDTH + 1)'(1))
                                  : (remaining_q == (ADDR_WIDTH + 1)'(1));
        push        = pipe_vld_q[PipeDepth-1];
        pop         = m_valid && m_ready;
    end

    assign rom_addr = rom_addr_q;
    assign m_valid  = (count_q != '0);
    assign m_data   = fifo_data_q[rd_ptr_q];
    assign m_last   = fifo_last_q[rd_ptr_q] && m_valid;
    assign done     = (state_q == StDone);
    // Covers the start cycle itself so busy spans start through the cycle before done.
    assign busy     = (state_q == StRun) || (state_q == StDrain) || start_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rom_addr_q  <= '0;
            remaining_q <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            fifo_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_data_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (length == '0) begin
                            state_q <= StDone;
                        end else if (length == (ADDR_WIDTH + 1)'(1)) begin
                            state_q <= StDrain;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (issue_next && issue_last) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (pop && m_last) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
            endcase

            if (issue_first) begin
                rom_addr_q  <= base_addr;
                remaining_q <= length - 1'b1;
            end else if (issue_next) begin
                rom_addr_q  <= rom_addr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
            end

            pipe_vld_q  <= {pipe_vld_q[PipeDepth-2:0], issue};
            pipe_last_q <= {pipe_last_q[PipeDepth-2:0], issue && issue_last};

            if (push) begin
                fifo_data_q[wr_ptr_q] <= rom_rd_data;
                fifo_last_q[wr_ptr_q] <= pipe_last_q[PipeDepth-1];
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule
